gpio_seq_arb: RTL
=================

// Module: gpio_seq_arb
// PURPOSE
//  Pattern sequencer and bus arbiter in front of the 15-bit GPIO port's register bus (AD/DI/rw/cs).
//  Replays up to 2^DEPTH_LOG2 15-bit output words at a programmable step period.
//  Shares the GPIO bus with the CPU; the CPU always has priority.
//  Sits on the CPU bus as its own 8-register peripheral. Drives only the GPIO output latch (AD 00/01), never direction.
// PARAMETERS
//  DEPTH_LOG2  4   log2 of pattern RAM entries (1..8)
//  DIV_W       16  step-period counter width
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  AD           in   3   sequencer register address
//  DI           in   8   CPU write data
//  DO           out  8   register read data, combinational on AD
//  rw           in   1   1=read 0=write
//  cs           in   1   sequencer register select
//  cpu_gpio_AD  in   2   CPU GPIO address
//  cpu_gpio_DI  in   8   CPU GPIO write data
//  cpu_gpio_rw  in   1   CPU GPIO rw
//  cpu_gpio_cs  in   1   CPU GPIO select
//  gpio_AD      out  2   to GPIO AD
//  gpio_DI      out  8   to GPIO DI
//  gpio_rw      out  1   to GPIO rw
//  gpio_cs      out  1   to GPIO cs
//  irq          out  1   done interrupt (SEQ_IRQ_EN only)
// BEHAVIOUR
//  Register map (write on posedge when cs & ~rw):
//    0 CTRL: b0 RUN, b1 LOOP, b2 BUSY (RO), b3 DONE (W1C), b4 IRQEN.
//    1 DIV_HI, 2 DIV_LO: step divider DIV.
//    3 LEN: low DEPTH_LOG2 bits; 0 means full depth.
//    4 PTR: RAM pointer.
//    5 DATA_HI: b6:0 staged.
//    6 DATA_LO: write RAM[PTR] = {hi, DI}; PTR++ with wrap. Read returns RAM[PTR] low byte.
//    7 STEP: RO, current step index.
//  Reset: all registers, RAM pointer and counter = 0; FSM = IDLE; irq = 0.
//  GPIO mux (combinational):
//    cpu_gpio_cs=1 -> pass the CPU signals through.
//    else FSM in WR_HI/WR_LO -> drive cs=1, rw=0, AD=00/01, DI={1'b0,hi}/lo.
//    else cs=0, rw=1, AD=0, DI=0.
//  FSM states:
//    IDLE: RUN written 0->1 -> STEP=0, go to WR_HI next cycle.
//    WR_HI: bus write of RAM[STEP][14:8]. Completes in a cycle with cpu_gpio_cs=0; otherwise stalls, nothing lost.
//    WR_LO: same, for [7:0].
//      On completion: load cnt=DIV.
//      If STEP==LEN-1: LOOP=1 -> STEP=0, WAIT; LOOP=0 -> DONE=1, RUN=0, IDLE.
//      Else STEP++, WAIT.
//    WAIT: cnt--; when cnt==0 -> WR_HI.
//  Timing: step period = DIV+3 clk with no stalls (minimum 3 at DIV=0). BUSY = (state != IDLE).
//  RUN cleared mid-run:
//    WAIT or WR_HI not yet done -> IDLE next cycle.
//    WR_LO pending -> finish WR_LO, then IDLE. The hi/lo pair is never split.
//    Abort does not set DONE.
//  RUN=1 written while BUSY: no restart.
//  RAM/DIV/LEN writes while running: take effect at the next read or load.
//  Simultaneous DONE-set and a W1C write: set wins.
//  Async rst mid-write: gpio_cs drops immediately.
// CONFIGURATION
//  SEQ_IRQ_EN defined: irq = DONE & IRQEN, registered; cleared by DONE W1C.
//  SEQ_IRQ_EN undefined: irq port tied 0; IRQEN bit reads 0.
// TESTING
//  Load RAM {0x1234,0x0ABC}, LEN=2, DIV=5, RUN:
//    -> GPIO writes 00:0x12,01:0x34, then 6 cycles of WAIT, then 00:0x0A,01:0xBC.
//    -> DONE=1, BUSY=0.
//  LOOP=1, LEN=3, DIV=0 -> continuous writes with period 3 clk, STEP sequence 0,1,2,0.
//  Hold cpu_gpio_cs=1 for 4 cycles during WR_HI:
//    -> CPU signals pass through; seq write deferred 4 cycles; no write lost.
//  Clear RUN in WR_LO -> the lo write still issues, then IDLE; DONE stays 0.
//  LEN=0, DEPTH_LOG2=4 -> 16 steps; PTR wraps 15->0 on DATA_LO write.
//  SEQ_IRQ_EN, IRQEN=1 -> irq rises 1 clk after DONE; W1C of CTRL b3 -> irq=0.

Source files
------------

// File: rtl/gpio_seq_arb.sv
// ============================================================================
// gpio_seq_arb
// ----------------------------------------------------------------------------
// Pattern sequencer and bus arbiter in front of a 15-bit GPIO port's
// register bus (AD/DI/rw/cs).
//
// The sequencer replays up to 2^DEPTH_LOG2 15-bit words out of a small
// pattern RAM. Each word is emitted as two GPIO output-latch writes:
// AD=00 carries bits 14:8 and AD=01 carries bits 7:0. Successive words are
// spaced by a programmable step period of DIV+3 clocks. The CPU shares the
// GPIO bus and always wins. A sequencer write that finds the bus taken
// simply waits, so no write is ever lost. The sequencer only touches the
// output latch and never the direction register.
//
// The block is also an 8-register peripheral on the CPU bus:
//   0 CTRL    b0 RUN, b1 LOOP, b2 BUSY (RO), b3 DONE (W1C), b4 IRQEN
//   1 DIV_HI  step divider, high byte
//   2 DIV_LO  step divider, low byte
//   3 LEN     pattern length (low DEPTH_LOG2 bits, 0 = full depth)
//   4 PTR     RAM pointer
//   5 DATA_HI bits 6:0 staged as word bits 14:8
//   6 DATA_LO write: RAM[PTR] = {DATA_HI, DI}, PTR++ (wraps)
//             read : low byte of RAM[PTR]
//   7 STEP    RO, current step index
//
// Parameters
//   DEPTH_LOG2  log2 of the number of pattern RAM entries (1..8)
//   DIV_W       step-period counter width (at most 16)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   AD, DI, DO, rw, cs       sequencer register bus (DO is combinational on AD)
//   cpu_gpio_AD/DI/rw/cs     CPU side of the shared GPIO bus
//   gpio_AD/DI/rw/cs         arbitrated GPIO bus (combinational mux)
//   irq                      done interrupt
//
// Configuration
//   SEQ_IRQ_EN  when defined, irq is a registered DONE & IRQEN and a DONE
//               W1C clears it. When undefined, irq is tied low and IRQEN
//               reads back as 0.
// ============================================================================
module gpio_seq_arb #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic [1:0] cpu_gpio_AD,
    input  logic [7:0] cpu_gpio_DI,
    input  logic       cpu_gpio_rw,
    input  logic       cpu_gpio_cs,
    output logic [1:0] gpio_AD,
    output logic [7:0] gpio_DI,
    output logic       gpio_rw,
    output logic       gpio_cs,
    output logic       irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_DIV_HI  = 3'd1;
    localparam logic [2:0] A_DIV_LO  = 3'd2;
    localparam logic [2:0] A_LEN     = 3'd3;
    localparam logic [2:0] A_PTR     = 3'd4;
    localparam logic [2:0] A_DATA_HI = 3'd5;
    localparam logic [2:0] A_DATA_LO = 3'd6;
    localparam logic [2:0] A_STEP    = 3'd7;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
    localparam logic [DIV_W-1:0]      CNT_ONE = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR_HI = 2'd1,
        S_WR_LO = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and configuration registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_run;
    logic                  r_done;
    logic                  r_loop;
    logic [7:0]            r_div_hi;
    logic [7:0]            r_div_lo;
    logic [DEPTH_LOG2-1:0] r_len;
    logic [DEPTH_LOG2-1:0] r_ptr;
    logic [DEPTH_LOG2-1:0] r_step;
    logic [6:0]            r_hi;
    logic [DIV_W-1:0]      r_cnt;
    logic [14:0]           r_ram [DEPTH];

    // ------------------------------------------------------------------
    // Register-bus decode and datapath helpers
    // ------------------------------------------------------------------
    logic                  w_wr;
    logic                  w_wr_ctrl;
    logic                  w_wr_div_hi;
    logic                  w_wr_div_lo;
    logic                  w_wr_len;
    logic                  w_wr_ptr;
    logic                  w_wr_data_hi;
    logic                  w_wr_data_lo;
    logic                  w_busy;
    logic                  w_bus_free;
    logic                  w_last_step;
    logic                  w_start;
    logic                  w_done_set;
    logic                  w_done_clr;
    logic                  w_irqen;
    logic                  w_drive_hi;
    logic                  w_drive_lo;
    logic [14:0]           w_cur_word;
    logic [15:0]           w_div;

    assign w_wr         = cs & ~rw;
    assign w_wr_ctrl    = w_wr & (AD == A_CTRL);
    assign w_wr_div_hi  = w_wr & (AD == A_DIV_HI);
    assign w_wr_div_lo  = w_wr & (AD == A_DIV_LO);
    assign w_wr_len     = w_wr & (AD == A_LEN);
    assign w_wr_ptr     = w_wr & (AD == A_PTR);
    assign w_wr_data_hi = w_wr & (AD == A_DATA_HI);
    assign w_wr_data_lo = w_wr & (AD == A_DATA_LO);

    assign w_busy      = (r_state != S_IDLE);
    assign w_bus_free  = ~cpu_gpio_cs;
    assign w_div       = {r_div_hi, r_div_lo};
    assign w_cur_word  = r_ram[r_step];

    // LEN=0 wraps to all-ones here, which is exactly the full-depth case.
    assign w_last_step = (r_step == (r_len - IDX_ONE));

    // Only a genuine 0->1 edge of RUN from IDLE starts a run. A RUN=1
    // written while still busy never restarts the pattern.
    assign w_start    = w_wr_ctrl & DI[0] & ~r_run & (r_state == S_IDLE);

    // A run ends normally only when the final low-byte write actually lands.
    assign w_done_set = (r_state == S_WR_LO) & w_bus_free & r_run &
                        w_last_step & ~r_loop;
    assign w_done_clr = w_wr_ctrl & DI[3];

    // The high-byte write is suppressed once RUN has dropped so that an
    // abort never leaves a lone high byte without its low byte. Once the
    // high byte has gone out, the low byte is always issued.
    assign w_drive_hi = (r_state == S_WR_HI) & r_run;
    assign w_drive_lo = (r_state == S_WR_LO);

    // ------------------------------------------------------------------
    // Sequencer FSM, including RUN/DONE which both CPU and FSM update
    // ------------------------------------------------------------------
    // Sequencer state machine with RUN/DONE/STEP/counter bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
            r_step  <= '0;
            r_cnt   <= '0;
        end else begin
            // CPU side first. The FSM assignments below take priority,
            // so a DONE set beats a simultaneous W1C.
            if (w_wr_ctrl) begin
                r_run <= DI[0];
                if (DI[3]) begin
                    r_done <= 1'b0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_step  <= '0;
                        r_state <= S_WR_HI;
                    end
                end

                S_WR_HI: begin
                    if (!r_run) begin
                        r_state <= S_IDLE;
                    end else if (w_bus_free) begin
                        r_state <= S_WR_LO;
                    end
                end

                S_WR_LO: begin
                    if (w_bus_free) begin
                        r_cnt <= w_div[DIV_W-1:0];
                        if (!r_run) begin
                            // Abort: the pair is complete, stop without DONE.
                            r_state <= S_IDLE;
                        end else if (w_last_step) begin
                            if (r_loop) begin
                                r_step  <= '0;
                                r_state <= S_WAIT;
                            end else begin
                                r_done  <= 1'b1;
                                r_run   <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_step  <= r_step + IDX_ONE;
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (!r_run) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_WR_HI;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CPU-programmed configuration and pattern RAM
    // ------------------------------------------------------------------
    // Loop flag, divider, length, pointer, staged high bits and RAM writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loop   <= 1'b0;
            r_div_hi <= 8'h00;
            r_div_lo <= 8'h00;
            r_len    <= '0;
            r_ptr    <= '0;
            r_hi     <= 7'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= 15'h0000;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_loop <= DI[1];
            end
            if (w_wr_div_hi) begin
                r_div_hi <= DI;
            end
            if (w_wr_div_lo) begin
                r_div_lo <= DI;
            end
            if (w_wr_len) begin
                r_len <= DI[DEPTH_LOG2-1:0];
            end
            if (w_wr_data_hi) begin
                r_hi <= DI[6:0];
            end
            if (w_wr_ptr) begin
                r_ptr <= DI[DEPTH_LOG2-1:0];
            end else if (w_wr_data_lo) begin
                r_ptr <= r_ptr + IDX_ONE;
            end
            if (w_wr_data_lo) begin
                r_ram[r_ptr] <= {r_hi, DI};
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional done interrupt
    // ------------------------------------------------------------------
`ifdef SEQ_IRQ_EN
    logic r_irqen;
    logic r_irq;

    // IRQEN storage and registered interrupt; a DONE W1C drops irq at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irqen <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_irqen <= DI[4];
            end
            if (w_done_clr && !w_done_set) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_done & r_irqen;
            end
        end
    end

    assign w_irqen = r_irqen;
    assign irq     = r_irq;
`else
    assign w_irqen = 1'b0;
    assign irq     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // GPIO bus arbitration: CPU first, then the sequencer, else idle
    // ------------------------------------------------------------------
    // Combinational GPIO mux so an async reset drops gpio_cs immediately
    always_comb begin
        gpio_AD = 2'b00;
        gpio_DI = 8'h00;
        gpio_rw = 1'b1;
        gpio_cs = 1'b0;
        if (cpu_gpio_cs) begin
            gpio_AD = cpu_gpio_AD;
            gpio_DI = cpu_gpio_DI;
            gpio_rw = cpu_gpio_rw;
            gpio_cs = 1'b1;
        end else if (w_drive_hi) begin
            gpio_AD = 2'b00;
            gpio_DI = {1'b0, w_cur_word[14:8]};
            gpio_rw = 1'b0;
            gpio_cs = 1'b1;
        end else if (w_drive_lo) begin
            gpio_AD = 2'b01;
            gpio_DI = w_cur_word[7:0];
            gpio_rw = 1'b0;
            gpio_cs = 1'b1;
        end else begin
            gpio_AD = 2'b00;
            gpio_DI = 8'h00;
            gpio_rw = 1'b1;
            gpio_cs = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register read-back
    // ------------------------------------------------------------------
    // Read data mux, combinational on AD
    always_comb begin
        DO = 8'h00;
        case (AD)
            A_CTRL:    DO = {3'b000, w_irqen, r_done, w_busy, r_loop, r_run};
            A_DIV_HI:  DO = r_div_hi;
            A_DIV_LO:  DO = r_div_lo;
            A_LEN:     DO = 8'(r_len);
            A_PTR:     DO = 8'(r_ptr);
            A_DATA_HI: DO = {1'b0, r_hi};
            A_DATA_LO: DO = r_ram[r_ptr][7:0];
            A_STEP:    DO = 8'(r_step);
            default:   DO = 8'h00;
        endcase
    end

endmodule
